uart_rx_core_param: RTL and testbench
=====================================

Name: uart_rx_core_param

Overview:
Parametrised next-generation UART receive engine: line synchroniser, oversampling majority-vote sampler, frame FSM, shift register and valid/ready output stage in one block.
Generalises the fixed 8-bit controller with configurable data width, stop-bit count, odd/even parity and overrun detection.
Sits between the raw rx pin and the host-side register interface.
Driven by an external baud-rate prescaler that supplies an oversampling tick.

Parameters:
- DATA_W, default 8, data bits per frame; legal range 5..9.
- OVS, default 8, ticks per bit (oversampling ratio); even, legal range 4..32.
- STOP_BITS, default 1, stop bits checked; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ovs_tick  in  1  one-cycle pulse, OVS pulses per bit period.
- rx_in  in  1  raw serial line, asynchronous to clk, idle high.
- par_en  in  1  1 = parity bit present; sampled at frame start.
- par_odd  in  1  1 = odd parity, 0 = even; sampled at frame start.
- rx_data  out  DATA_W  received word, LSB first on the line.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- frame_err  out  1  one-cycle pulse: a stop bit sampled 0.
- overrun_err  out  1  one-cycle pulse: good frame lost because rx_valid was still high.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, all error pulses=0, busy=0.
  - Synchroniser flops reset to 1.
  - Tick counter, bit counter and FSM reset to 0 / IDLE.
- Reset asserted mid-frame aborts the frame immediately; no error pulse is produced.
- rx_in passes through a 2-flop synchroniser before any use.
- Tick counter: width clog2(OVS); advances only on ovs_tick.
- Majority vote: samples taken at tick counts OVS/2-1, OVS/2 and OVS/2+1. The bit decision is made at OVS/2+1 and equals 2-of-3.
- FSM states: IDLE, START, DATA, PARITY, STOP, DELIVER.
  - IDLE: on an ovs_tick with synchronised rx==0, go to START and clear the tick counter. Latch par_en/par_odd at this point.
  - START: at the decision point, vote==1 is a glitch: return to IDLE silently. Vote==0: go to DATA, bit counter=0.
  - DATA: one bit per OVS ticks, shifted in LSB-first. After DATA_W bits, go to PARITY if par_en is latched, else STOP.
  - PARITY: compute the expected bit as XOR of the data bits XOR par_odd; a mismatch is recorded.
  - STOP: sample STOP_BITS bits; any 0 is recorded as a frame error. After the last stop-bit decision go to DELIVER. The FSM does not wait for the stop-bit end, allowing resync on a back-to-back start edge.
  - DELIVER: exactly one clk cycle, then IDLE.
- In the DELIVER cycle:
  - Frame error: pulse frame_err. Parity is not reported, rx_data/rx_valid are unchanged.
  - Else parity error: pulse parity_err. rx_data/rx_valid are unchanged.
  - Else good frame, rx_valid=0 or rx_ready=1: load rx_data and set rx_valid on the next edge.
  - Else good frame, rx_valid=1 and rx_ready=0: pulse overrun_err. The old rx_data is kept and the new word is dropped.
- rx_valid clears on the cycle after rx_valid && rx_ready, unless a new word is loaded in the same cycle; the load wins.
- Latency: rx_valid rises 1 clk after the DELIVER cycle, i.e. 2 clk after the last stop-bit decision tick.

Optional Feature:
UART_RX_BREAK_DET_EN
- With the macro:
  - An extra output, break_det (1 bit, reset 0), is added.
  - A frame with all data bits 0, parity 0 (if enabled) and stop bit 0 pulses break_det instead of frame_err.
  - The FSM then holds in STOP until the synchronised rx is 1 for one full OVS-tick bit period, then goes to IDLE.
- Without the macro: the port is absent, and such a frame is a normal frame_err.

Decomposition:
- Package uart_rx_pkg:
  - state typedef (gray-coded 3-bit, matching the existing controller encoding style);
  - PAR_EVEN/PAR_ODD constants;
  - a function for the 2-of-3 majority vote.
- One sub-module: uart_rx_sampler, containing the synchroniser, tick counter and majority vote. Outputs: bit_value, bit_strobe (decision point), start_edge. The FSM, shift register, parity and output stage stay in the top.

Test Plan:
- OVS=8, DATA_W=8, par_en=0, rx_ready=1, send 0xA5 → rx_data=0xA5, rx_valid high 1 cycle, no errors, busy low after DELIVER.
- par_en=1, par_odd=0, send 0x37 with parity bit 1 → rx_data=0x37, valid. Repeat with parity bit 0 → parity_err pulse, rx_valid stays 0, rx_data still 0x37.
- Send 0x5A with stop bit 0 → frame_err pulse only, no parity_err, no rx_valid.
- rx_in low for 2 ticks then high → busy rises then falls after the START decision, no outputs, no errors.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 held, rx_valid=1, overrun_err pulses once at the end of 0x22.
- Assert rst during data bit 4 of 0xFF → all outputs return to reset values; the following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, parity constants and majority-vote helper for the UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    START   = 3'b001,
    DATA    = 3'b011,
    PARITY  = 3'b010,
    STOP    = 3'b110,
    DELIVER = 3'b111
  } state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchroniser, oversampling tick counter and 2-of-3 mid-bit vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ovs_tick,
  input  logic rx_in,
  input  logic clr,
  output logic bit_value,
  output logic bit_strobe,
  output logic start_edge
);
  localparam int CW = $clog2(OVS);
  logic meta, rx_sync, s0, s1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      s0      <= 1'b1;
      s1      <= 1'b1;
      cnt     <= '0;
    end else begin
      meta    <= rx_in;
      rx_sync <= meta;
      if (clr) cnt <= '0;
      else if (ovs_tick) cnt <= (cnt == CW'(OVS - 1)) ? '0 : cnt + 1'b1;
      if (ovs_tick && cnt == CW'(OVS / 2 - 1)) s0 <= rx_sync;
      if (ovs_tick && cnt == CW'(OVS / 2)) s1 <= rx_sync;
    end
  assign bit_strobe = ovs_tick && cnt == CW'(OVS / 2 + 1);
  assign bit_value  = maj3(s0, s1, rx_sync);
  assign start_edge = ovs_tick && !rx_sync;
endmodule

// File: rtl/uart_rx_core_param.sv
// uart_rx_core_param: parametrised UART receive engine (frame FSM, shift register, parity, valid/ready output).
// Optional break detection with UART_RX_BREAK_DET_EN.
module uart_rx_core_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OVS       = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ovs_tick,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_odd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              busy
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic              break_det
`endif
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic par_en_q, par_odd_q, par_bad, frm_bad;
  logic bit_value, bit_strobe, start_edge;
`ifdef UART_RX_BREAK_DET_EN
  localparam int CW = $clog2(OVS);
  logic par_bit, brk_wait;
  logic [CW-1:0] hold_cnt;
`endif
  uart_rx_sampler #(.OVS(OVS)) u_sampler (
    .clk(clk),
    .rst(rst),
    .ovs_tick(ovs_tick),
    .rx_in(rx_in),
    .clr(state == IDLE && start_edge),
    .bit_value(bit_value),
    .bit_strobe(bit_strobe),
    .start_edge(start_edge)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      par_bad     <= 1'b0;
      frm_bad     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det   <= 1'b0;
      par_bit     <= 1'b0;
      brk_wait    <= 1'b0;
      hold_cnt    <= '0;
`endif
    end else begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det   <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          state     <= START;
          par_en_q  <= par_en;
          par_odd_q <= par_odd;
        end
        START: if (bit_strobe) begin
          state   <= bit_value ? IDLE : DATA;
          bit_cnt <= '0;
          par_bad <= 1'b0;
          frm_bad <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          par_bit <= 1'b0;
`endif
        end
        DATA: if (bit_strobe) begin
          shreg   <= {bit_value, shreg[DATA_W-1:1]};
          bit_cnt <= (bit_cnt == BW'(DATA_W - 1)) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_W - 1)) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: if (bit_strobe) begin
          par_bad <= bit_value != (^shreg ^ (par_odd_q == PAR_ODD));
          state   <= STOP;
`ifdef UART_RX_BREAK_DET_EN
          par_bit <= bit_value;
`endif
        end
        STOP:
`ifdef UART_RX_BREAK_DET_EN
          // A tick without start_edge means the synchronised line was high on that tick.
          if (brk_wait) begin
            if (ovs_tick) begin
              hold_cnt <= start_edge ? '0 : hold_cnt + 1'b1;
              if (!start_edge && hold_cnt == CW'(OVS - 1)) begin
                state    <= IDLE;
                brk_wait <= 1'b0;
              end
            end
          end else
`endif
          if (bit_strobe) begin
            if (!bit_value) frm_bad <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
`ifdef UART_RX_BREAK_DET_EN
              if (!bit_value && shreg == '0 && !par_bit) begin
                break_det <= 1'b1;
                brk_wait  <= 1'b1;
                hold_cnt  <= '0;
              end else
`endif
              state <= DELIVER;
            end
          end
        DELIVER: begin
          state <= IDLE;
          if (frm_bad) frame_err <= 1'b1;
          else if (par_bad) parity_err <= 1'b1;
          else if (!rx_valid || rx_ready) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
          end else overrun_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_core_param.sv
// tb_uart_rx_core_param: directed frames (good, parity, framing, glitch, overrun, mid-frame reset).
module tb_uart_rx_core_param;
  logic clk = 1'b0, rst = 1'b1, ovs_tick = 1'b0, rx_in = 1'b1;
  logic par_en = 1'b0, par_odd = 1'b0, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, overrun_err, busy;
`ifdef UART_RX_BREAK_DET_EN
  logic break_det;
`endif
  int errors = 0, checks = 0;
  int n_pe = 0, n_fe = 0, n_oe = 0, n_v = 0, n_busy = 0;
  int b_pe, b_fe, b_oe, b_v, b_busy;
  always #5 clk = ~clk;
  uart_rx_core_param dut (
    .clk(clk),
    .rst(rst),
    .ovs_tick(ovs_tick),
    .rx_in(rx_in),
    .par_en(par_en),
    .par_odd(par_odd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .busy(busy)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .break_det(break_det)
`endif
  );
  initial forever begin
    repeat (3) @(negedge clk);
    ovs_tick = 1'b1;
    @(negedge clk);
    ovs_tick = 1'b0;
  end
  always @(negedge clk) begin
    if (parity_err) n_pe++;
    if (frame_err) n_fe++;
    if (overrun_err) n_oe++;
    if (rx_valid) n_v++;
    if (busy) n_busy++;
  end
  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task snap;
    b_pe = n_pe; b_fe = n_fe; b_oe = n_oe; b_v = n_v; b_busy = n_busy;
  endtask
  task bitp(input logic v);
    rx_in = v;
    repeat (32) @(negedge clk);
  endtask
  task send(input logic [7:0] d, input logic pb_en, input logic pb, input logic sb, input int idle);
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(d[i]);
    if (pb_en) bitp(pb);
    bitp(sb);
    rx_in = 1'b1;
    repeat (idle * 32) @(negedge clk);
  endtask
  initial begin
    repeat (4) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    snap;
    send(8'hA5, 1'b0, 1'b0, 1'b1, 2);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid_cycles", n_v - b_v, 1);
    check("a5_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_oe - b_oe), 0);
    check("a5_busy_seen", n_busy > b_busy, 1);
    check("a5_busy_end", busy, 1'b0);
    par_en = 1'b1;
    snap;
    send(8'h37, 1'b1, 1'b1, 1'b1, 2);
    check("p37_data", rx_data, 8'h37);
    check("p37_valid_cycles", n_v - b_v, 1);
    check("p37_pe", n_pe - b_pe, 0);
    snap;
    send(8'h37, 1'b1, 1'b0, 1'b1, 2);
    check("pbad_pe", n_pe - b_pe, 1);
    check("pbad_valid", n_v - b_v, 0);
    check("pbad_data", rx_data, 8'h37);
    snap;
    send(8'h5A, 1'b1, 1'b1, 1'b0, 2);
    check("fe_fe", n_fe - b_fe, 1);
    check("fe_pe", n_pe - b_pe, 0);
    check("fe_valid", n_v - b_v, 0);
    par_en = 1'b0;
    snap;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rx_in = 1'b1;
    repeat (64) @(negedge clk);
    check("glitch_busy_seen", n_busy > b_busy, 1);
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_valid", n_v - b_v, 0);
    check("glitch_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_oe - b_oe), 0);
    rx_ready = 1'b0;
    snap;
    send(8'h11, 1'b0, 1'b0, 1'b1, 0);
    check("ovr_first_data", rx_data, 8'h11);
    check("ovr_first_valid", rx_valid, 1'b1);
    send(8'h22, 1'b0, 1'b0, 1'b1, 2);
    check("ovr_oe", n_oe - b_oe, 1);
    check("ovr_held_data", rx_data, 8'h11);
    check("ovr_held_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_consumed", rx_valid, 1'b0);
    snap;
    bitp(1'b0);
    for (int i = 0; i < 4; i++) bitp(1'b1);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", rx_data, 8'h00);
    check("mrst_valid", rx_valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    check("mrst_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_oe - b_oe), 0);
    snap;
    send(8'h3C, 1'b0, 1'b0, 1'b1, 2);
    check("post_data", rx_data, 8'h3C);
    check("post_valid_cycles", n_v - b_v, 1);
    check("post_errs", (n_pe - b_pe) + (n_fe - b_fe) + (n_oe - b_oe), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
